// File: rtl/enc8_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : enc8_serializer_if
// Description : Line-vector input stream and code output stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface enc8_serializer_if #(
    parameter int N = 8
);
    localparam int CODE_W = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_lines;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              out_zero;

    modport master (
        output in_valid, in_lines, out_ready,
        input  in_ready, out_valid, out_code, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_lines, out_ready,
        output in_ready, out_valid, out_code, out_last, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/enc8_serializer.sv
`default_nettype none
// ============================================================================
// Module      : enc8_serializer
// Description : Sequential 8-to-3 encoder; emits the index of every asserted
//               line of a captured vector, one beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module enc8_serializer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    enc8_serializer_if.slave  bus
);
    localparam int CODE_W = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [N-1:0]      r_pending;
    logic              r_zero;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_code;
    logic              r_out_last;
    logic              r_out_zero;
    logic [N-1:0]      w_remaining;

    // Index of the next line to emit in scan order; 0 for an empty vector.
    function automatic logic [CODE_W-1:0] f_pick(input logic [N-1:0] vec);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < N; i++) begin
            if (LSB_FIRST) begin
                if (vec[N-1-i]) code = CODE_W'(N - 1 - i);
            end else begin
                if (vec[i]) code = CODE_W'(i);
            end
        end
        return code;
    endfunction

    function automatic logic f_single(input logic [N-1:0] vec);
        return (vec != '0) && ((vec & (vec - N'(1))) == '0);
    endfunction

    assign w_remaining = r_pending & ~(N'(1) << r_out_code);

    assign bus.in_ready  = (r_state == ST_IDLE) && rst_n;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_last  = r_out_last;
    assign bus.out_zero  = r_out_zero;

    // Beat fields are precomputed from the next pending value so they leave
    // the block straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_last  <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        r_state     <= ST_EMIT;
                        r_pending   <= bus.in_lines;
                        r_zero      <= (bus.in_lines == '0);
                        r_out_valid <= 1'b1;
                        r_out_code  <= f_pick(bus.in_lines);
                        r_out_last  <= (bus.in_lines == '0) || f_single(bus.in_lines);
                        r_out_zero  <= (bus.in_lines == '0);
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_pending   <= '0;
                            r_zero      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_code  <= '0;
                            r_out_last  <= 1'b0;
                            r_out_zero  <= 1'b0;
                        end else begin
                            r_pending  <= w_remaining;
                            r_out_code <= f_pick(w_remaining);
                            r_out_last <= f_single(w_remaining);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_enc8_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc8_serializer
// Description : Scoreboard bench for enc8_serializer, ascending and descending.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc8_serializer;
    typedef struct packed {
        logic [2:0] code;
        logic       last;
        logic       zero;
    } beat_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    beat_t q0[$];
    beat_t q1[$];
    beat_t prev[2];
    bit    stall[2];

    enc8_serializer_if #(.N(8)) bus0 ();
    enc8_serializer_if #(.N(8)) bus1 ();

    enc8_serializer #(.N(8), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    enc8_serializer #(.N(8), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? bus0.out_valid : bus1.out_valid;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    task automatic push(input int sel, input logic [2:0] code, input logic last, input logic zero);
        beat_t b;
        b.code = code;
        b.last = last;
        b.zero = zero;
        if (sel == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic mon(input int sel);
        logic  v;
        logic  r;
        beat_t b;
        beat_t e;
        if (sel == 0) begin
            v = bus0.out_valid; r = bus0.out_ready;
            b = {bus0.out_code, bus0.out_last, bus0.out_zero};
        end else begin
            v = bus1.out_valid; r = bus1.out_ready;
            b = {bus1.out_code, bus1.out_last, bus1.out_zero};
        end
        if (stall[sel] && rst_n) begin
            check($sformatf("hold_valid%0d", sel), 32'(v), 32'd1);
            check($sformatf("hold_beat%0d", sel), 32'(b), 32'(prev[sel]));
        end
        if (rst_n && v && r) begin
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat%0d: got beat %0h expected none at %0t", sel, b, $time);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("beat%0d", sel), 32'(b), 32'(e));
            end
        end
        stall[sel] = rst_n && v && !r;
        prev[sel]  = b;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic send(input int sel, input logic [7:0] vec);
        int n;
        n = 0;
        if (sel == 0) begin bus0.in_valid = 1'b1; bus0.in_lines = vec; end
        else          begin bus1.in_valid = 1'b1; bus1.in_lines = vec; end
        do begin
            @(negedge clk);
            n++;
        end while (!get_ready(sel) && n < 50);
        if (n >= 50) check("accept_timeout", 32'(get_ready(sel)), 32'd1);
        @(posedge clk);
        #1;
        if (sel == 0) bus0.in_valid = 1'b0;
        else          bus1.in_valid = 1'b0;
        check("first_beat_latency", 32'(get_valid(sel)), 32'd1);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (n < 100 && (get_valid(sel) || (sel == 0 ? q0.size() : q1.size()) != 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(get_valid(sel)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_lines = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_lines = '0; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        check("rst_out_fields", 32'({bus0.out_valid, bus0.out_code, bus0.out_last, bus0.out_zero}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 32'(bus0.in_ready), 32'd1);

        // Single line
        push(0, 3'd2, 1'b1, 1'b0);
        send(0, 8'b0000_0100);
        @(posedge clk); #1;
        check("single_ready_back", 32'(bus0.in_ready), 32'd1);
        check("single_idle_valid", 32'(bus0.out_valid), 32'd0);

        // Multi-hot ascending
        push(0, 3'd1, 1'b0, 1'b0);
        push(0, 3'd4, 1'b0, 1'b0);
        push(0, 3'd7, 1'b1, 1'b0);
        send(0, 8'b1001_0010);
        repeat (2) @(posedge clk);
        #1;
        check("multi_busy", 32'(bus0.in_ready), 32'd0);
        @(posedge clk); #1;
        check("multi_ready_back", 32'(bus0.in_ready), 32'd1);

        // Zero vector
        push(0, 3'd0, 1'b1, 1'b1);
        send(0, 8'h00);
        @(posedge clk); #1;
        check("zero_ready_back", 32'(bus0.in_ready), 32'd1);

        // Backpressure with a competing vector offered during EMIT
        push(0, 3'd0, 1'b0, 1'b0);
        push(0, 3'd1, 1'b1, 1'b0);
        bus0.out_ready = 1'b0;
        send(0, 8'b0000_0011);
        bus0.in_valid = 1'b1;
        bus0.in_lines = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("emit_in_ready", 32'(bus0.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        wait_idle(0);

        push(0, 3'd7, 1'b1, 1'b0);
        send(0, 8'h80);
        wait_idle(0);

        // Reset mid-frame after codes 0 and 1
        push(0, 3'd0, 1'b0, 1'b0);
        push(0, 3'd1, 1'b0, 1'b0);
        send(0, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus0.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("midrst_in_ready_back", 32'(bus0.in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_quiet", 32'(bus0.out_valid), 32'd0);

        // Descending order
        push(1, 3'd7, 1'b0, 1'b0);
        push(1, 3'd4, 1'b0, 1'b0);
        push(1, 3'd1, 1'b1, 1'b0);
        send(1, 8'b1001_0010);
        wait_idle(1);
        push(1, 3'd0, 1'b1, 1'b0);
        send(1, 8'b0000_0001);
        wait_idle(1);
        push(1, 3'd0, 1'b1, 1'b1);
        send(1, 8'h00);
        wait_idle(1);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
